pipe_dmem_resp: RTL and testbench

Responder side of the MEM-stage data-memory interface in the five-stage MIPS pipeline. It accepts one load/store request at a time from the MEM stage over a ready/valid handshake and owns the word-wide synchronous data RAM. Byte and halfword stores are implemented as read-modify-write, and byte and halfword loads are sign- or zero-extended. It returns the load data, or a completion pulse for stores, plus an error flag.

---
 rtl/pipe_dmem_resp.sv | 189 ++++++++++++++++++
 tb/tb_pipe_dmem_resp.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_dmem_resp.sv
// MEM-stage data-memory responder: word RAM, sub-word RMW stores, extended loads.
// Define PIPE_DMEM_ERR_EN to enable alignment, range and type error checks.
module pipe_dmem_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_req,
    input  logic        in_wena,
    input  logic [1:0]  in_dmem_type,
    input  logic        in_load_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_ready,
    output logic        out_resp_valid,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          wena_q, wena_d;
    logic [1:0]    type_q, type_d;
    logic          uns_q, uns_d;
    logic [1:0]    lane_q, lane_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   ram_rd_q;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;

    logic [31:0]   offset;
    logic [AW-1:0] req_idx;
    logic          req_err;
    logic          req_sub_store;
    logic          accept;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    assign offset  = in_addr - BASE_ADDR;
    assign req_idx = offset[AW+1:2];

`ifdef PIPE_DMEM_ERR_EN
    always_comb begin
        req_err = 1'b0;
        case (in_dmem_type)
            2'b00:   req_err = (offset[1:0] != 2'b00);
            2'b01:   req_err = offset[0];
            2'b10:   req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
        // offsets below the base wrap high and land here too
        if (offset[31:AW+2] != '0) req_err = 1'b1;
    end
`else
    logic unused_offset;
    assign unused_offset = ^offset;
    assign req_err = 1'b0;
`endif

    assign req_sub_store = in_wena
                         & ((in_dmem_type == 2'b01) | (in_dmem_type == 2'b10));
    assign out_ready = (state_q != RD_WAIT);
    assign accept    = in_req & out_ready & ~in_rst;

    always_comb begin
        byte_sel = ram_rd_q[7:0];
        case (lane_q)
            2'd0: byte_sel = ram_rd_q[7:0];
            2'd1: byte_sel = ram_rd_q[15:8];
            2'd2: byte_sel = ram_rd_q[23:16];
            2'd3: byte_sel = ram_rd_q[31:24];
        endcase
        half_sel = lane_q[1] ? ram_rd_q[31:16] : ram_rd_q[15:0];
        case (type_q)
            2'b10:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = ram_rd_q;
        endcase
        merged = ram_rd_q;
        if (type_q == 2'b10) begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        wena_d    = wena_q;
        type_d    = type_q;
        uns_d     = uns_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = merged;
        if (state_q == RD_WAIT) begin
            state_d = RESP;
            err_d   = 1'b0;
            if (wena_q) begin
                ram_we  = 1'b1;
                rdata_d = 32'h0;
            end else begin
                rdata_d = load_ext;
            end
        end else if (accept) begin
            wena_d  = in_wena;
            type_d  = in_dmem_type;
            uns_d   = in_load_unsigned;
            lane_d  = offset[1:0];
            wdata_d = in_wdata[15:0];
            idx_d   = req_idx;
            rdata_d = 32'h0;
            err_d   = req_err;
            if (req_err) begin
                state_d = RESP;
            end else if (in_wena && !req_sub_store) begin
                ram_we    = 1'b1;
                ram_waddr = req_idx;
                ram_wdata = in_wdata;
                state_d   = RESP;
            end else begin
                ram_re  = 1'b1;
                state_d = RD_WAIT;
            end
        end else begin
            state_d = IDLE;
        end
        // reset drops a pending RMW write
        if (in_rst) ram_we = 1'b0;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            wena_q  <= 1'b0;
            type_q  <= 2'b00;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= 16'h0;
            idx_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wena_q  <= wena_d;
            type_q  <= type_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge in_clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rd_q <= mem[req_idx];
    end

    assign out_resp_valid = (state_q == RESP);
    assign out_rdata      = rdata_q;
    assign out_err        = err_q;

endmodule

// File: tb/tb_pipe_dmem_resp.sv
// Directed bench for pipe_dmem_resp; expectations follow PIPE_DMEM_ERR_EN.
module tb_pipe_dmem_resp;

`ifdef PIPE_DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_req;
    logic        in_wena;
    logic [1:0]  in_dmem_type;
    logic        in_load_unsigned;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        out_ready;
    logic        out_resp_valid;
    logic [31:0] out_rdata;
    logic        out_err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat;
    logic        rdy1;
    logic        er;
    logic [31:0] rd;

    pipe_dmem_resp dut (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_req           (in_req),
        .in_wena          (in_wena),
        .in_dmem_type     (in_dmem_type),
        .in_load_unsigned (in_load_unsigned),
        .in_addr          (in_addr),
        .in_wdata         (in_wdata),
        .out_ready        (out_ready),
        .out_resp_valid   (out_resp_valid),
        .out_rdata        (out_rdata),
        .out_err          (out_err)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request and collect latency, ready-after-accept and response.
    task automatic transact(
        input  logic        w,
        input  logic [1:0]  t,
        input  logic        u,
        input  logic [31:0] a,
        input  logic [31:0] d,
        output int          l,
        output logic        r1,
        output logic [31:0] rdat,
        output logic        e
    );
        int g;
        l    = -1;
        r1   = 1'bx;
        rdat = 'x;
        e    = 1'bx;
        g    = 0;
        while (!out_ready && g < 10) begin
            @(posedge in_clk); #1;
            g++;
        end
        in_req = 1'b1;
        in_wena = w;
        in_dmem_type = t;
        in_load_unsigned = u;
        in_addr = a;
        in_wdata = d;
        @(posedge in_clk); #1;
        in_req = 1'b0;
        r1 = out_ready;
        for (int c = 1; c <= 3; c++) begin
            if (out_resp_valid) begin
                l = c;
                rdat = out_rdata;
                e = out_err;
                break;
            end
            @(posedge in_clk); #1;
        end
    endtask

    task automatic test_reset();
        in_rst = 1'b1;
        in_req = 1'b0;
        in_wena = 1'b0;
        in_dmem_type = 2'b00;
        in_load_unsigned = 1'b0;
        in_addr = 32'h0;
        in_wdata = 32'h0;
        repeat (2) @(posedge in_clk);
        #1;
        n_chk++;
        if (out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", out_ready);
        end
        n_chk++;
        if (out_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", out_resp_valid);
        end
        n_chk++;
        if (out_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", out_rdata);
        end
        n_chk++;
        if (out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", out_err);
        end
        in_rst = 1'b0;
        @(posedge in_clk); #1;
    endtask

    task automatic test_word();
        transact(1, 2'b00, 0, 32'h10010008, 32'h11223344, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== 1 || rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL word_store_lat: got %0d/%b want 1/1", lat, rdy1);
        end
        n_chk++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL word_store_resp: got %h/%b want 0/0", rd, er);
        end
        @(posedge in_clk); #1;
        n_chk++;
        if (out_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL word_pulse_len: got %b want 0", out_resp_valid);
        end
        transact(0, 2'b00, 0, 32'h10010008, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== 2 || rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL word_load_lat: got %0d/%b want 2/0", lat, rdy1);
        end
        n_chk++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL word_load: got %h/%b want 11223344/0", rd, er);
        end
    endtask

    task automatic test_byte();
        transact(1, 2'b10, 0, 32'h10010009, 32'h123456AB, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_store: got %0d/%h/%b want 2/0/0", lat, rd, er);
        end
        transact(0, 2'b00, 0, 32'h10010008, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h1122AB44) begin
            n_fail++;
            $display("FAIL byte_rmw: got %h want 1122ab44", rd);
        end
        transact(0, 2'b10, 0, 32'h10010009, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'hFFFFFFAB || lat !== 2) begin
            n_fail++;
            $display("FAIL byte_lds: got %h/%0d want ffffffab/2", rd, lat);
        end
        transact(0, 2'b10, 1, 32'h10010009, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h000000AB) begin
            n_fail++;
            $display("FAIL byte_ldu: got %h want 000000ab", rd);
        end
        transact(0, 2'b10, 0, 32'h1001000B, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h00000011) begin
            n_fail++;
            $display("FAIL byte_lane3: got %h want 00000011", rd);
        end
    endtask

    task automatic test_half();
        transact(1, 2'b01, 0, 32'h1001000A, 32'hFFFF8001, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL half_store: got %0d/%b want 2/0", lat, er);
        end
        transact(0, 2'b00, 0, 32'h10010008, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h8001AB44) begin
            n_fail++;
            $display("FAIL half_rmw: got %h want 8001ab44", rd);
        end
        transact(0, 2'b01, 0, 32'h1001000A, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL half_lds: got %h want ffff8001", rd);
        end
        transact(0, 2'b01, 1, 32'h10010008, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h0000AB44) begin
            n_fail++;
            $display("FAIL half_ldu_lo: got %h want 0000ab44", rd);
        end
        transact(0, 2'b01, 0, 32'h1001000B, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== (ERR_EN ? 1 : 2) || er !== ERR_EN) begin
            n_fail++;
            $display("FAIL half_misalign: got %0d/%b want %0d/%b",
                     lat, er, ERR_EN ? 1 : 2, ERR_EN);
        end
        n_chk++;
        if (rd !== (ERR_EN ? 32'h0 : 32'hFFFF8001)) begin
            n_fail++;
            $display("FAIL half_misalign_data: got %h", rd);
        end
        transact(1, 2'b01, 0, 32'h1001000B, 32'h00005555, lat, rdy1, rd, er);
        transact(0, 2'b00, 0, 32'h10010008, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== (ERR_EN ? 32'h8001AB44 : 32'h5555AB44)) begin
            n_fail++;
            $display("FAIL half_misalign_store: got %h", rd);
        end
        transact(1, 2'b01, 0, 32'h1001000A, 32'h00008001, lat, rdy1, rd, er);
    endtask

    task automatic test_back_to_back();
        in_req = 1'b1;
        in_wena = 1'b1;
        in_dmem_type = 2'b00;
        in_load_unsigned = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_addr = 32'h10010020 + 32'(4 * i);
            in_wdata = 32'hA5000000 | 32'(i);
            @(posedge in_clk); #1;
            n_chk++;
            if (out_resp_valid !== 1'b1 || out_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_store%0d: got valid=%b ready=%b want 1/1",
                         i, out_resp_valid, out_ready);
            end
        end
        in_req = 1'b0;
        transact(0, 2'b00, 0, 32'h1001002C, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'hA5000003) begin
            n_fail++;
            $display("FAIL b2b_read3: got %h want a5000003", rd);
        end
        transact(0, 2'b00, 0, 32'h10010024, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'hA5000001 || lat !== 2 || rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL alt_load1: got %h/%0d/%b want a5000001/2/0",
                     rd, lat, rdy1);
        end
        transact(1, 2'b00, 0, 32'h10010024, 32'h0BADF00D, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== 1 || rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL alt_store: got %0d/%b want 1/1", lat, rdy1);
        end
        transact(0, 2'b00, 0, 32'h10010024, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h0BADF00D || lat !== 2 || rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL alt_load2: got %h/%0d/%b want 0badf00d/2/0",
                     rd, lat, rdy1);
        end
    endtask

    task automatic test_reset_mid_op();
        in_req = 1'b1;
        in_wena = 1'b1;
        in_dmem_type = 2'b10;
        in_load_unsigned = 1'b0;
        in_addr = 32'h10010008;
        in_wdata = 32'h000000EE;
        @(posedge in_clk); #1;
        in_req = 1'b0;
        n_chk++;
        if (out_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_rdwait: got ready=%b want 0", out_ready);
        end
        in_rst = 1'b1;
        @(posedge in_clk); #1;
        n_chk++;
        if (out_resp_valid !== 1'b0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_state: got valid=%b ready=%b want 0/1",
                     out_resp_valid, out_ready);
        end
        in_rst = 1'b0;
        @(posedge in_clk); #1;
        n_chk++;
        if (out_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_noresp: got %b want 0", out_resp_valid);
        end
        transact(0, 2'b00, 0, 32'h10010008, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h8001AB44) begin
            n_fail++;
            $display("FAIL rst_mid_ram: got %h want 8001ab44", rd);
        end
        in_rst = 1'b1;
        in_req = 1'b1;
        in_wena = 1'b1;
        in_dmem_type = 2'b00;
        in_addr = 32'h10010008;
        in_wdata = 32'hDEADBEEF;
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        in_req = 1'b0;
        @(posedge in_clk); #1;
        n_chk++;
        if (out_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_resp: got %b want 0", out_resp_valid);
        end
        transact(0, 2'b00, 0, 32'h10010008, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== 32'h8001AB44) begin
            n_fail++;
            $display("FAIL rst_req_ram: got %h want 8001ab44", rd);
        end
    endtask

    task automatic test_errors();
        transact(1, 2'b00, 0, 32'h10010000, 32'h5A5A0001, lat, rdy1, rd, er);
        transact(1, 2'b00, 0, 32'h10010FFC, 32'hCAFE0123, lat, rdy1, rd, er);
        transact(1, 2'b00, 0, 32'h10010004, 32'h01020304, lat, rdy1, rd, er);
        transact(0, 2'b00, 0, 32'h10011000, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== (ERR_EN ? 1 : 2) || er !== ERR_EN
            || rd !== (ERR_EN ? 32'h0 : 32'h5A5A0001)) begin
            n_fail++;
            $display("FAIL oor_high: got %0d/%b/%h", lat, er, rd);
        end
        transact(0, 2'b00, 0, 32'h1000FFFC, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== (ERR_EN ? 1 : 2) || er !== ERR_EN
            || rd !== (ERR_EN ? 32'h0 : 32'hCAFE0123)) begin
            n_fail++;
            $display("FAIL oor_below: got %0d/%b/%h", lat, er, rd);
        end
        transact(0, 2'b00, 0, 32'h10010002, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== (ERR_EN ? 1 : 2) || er !== ERR_EN
            || rd !== (ERR_EN ? 32'h0 : 32'h5A5A0001)) begin
            n_fail++;
            $display("FAIL misalign_word: got %0d/%b/%h", lat, er, rd);
        end
        transact(1, 2'b11, 0, 32'h10010004, 32'h77777777, lat, rdy1, rd, er);
        n_chk++;
        if (lat !== 1 || er !== ERR_EN) begin
            n_fail++;
            $display("FAIL type11_store: got %0d/%b want 1/%b", lat, er, ERR_EN);
        end
        transact(0, 2'b00, 0, 32'h10010004, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== (ERR_EN ? 32'h01020304 : 32'h77777777)) begin
            n_fail++;
            $display("FAIL type11_ram: got %h", rd);
        end
        transact(1, 2'b00, 0, 32'h10011000, 32'hFFFF0000, lat, rdy1, rd, er);
        transact(0, 2'b00, 0, 32'h10010000, 32'h0, lat, rdy1, rd, er);
        n_chk++;
        if (rd !== (ERR_EN ? 32'h5A5A0001 : 32'hFFFF0000) || er !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_store_ram: got %h/%b", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_back_to_back();
        test_reset_mid_op();
        test_errors();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
